// File: rtl/mmio_pkg.sv
// Shared types and constants for the MMIO master.
// Holds the FSM state encoding and the MMIO address window.
package mmio_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    localparam logic [15:0] MMIO_WINDOW_HI = 16'hFFFF;
    localparam logic [15:0] REG1_OFF       = 16'h0000;
    localparam logic [15:0] REG2_OFF       = 16'h0004;

    function automatic logic in_window(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1:16] == MMIO_WINDOW_HI;
    endfunction

endpackage

// File: rtl/mmio_master_if.sv
// Request/response handshake plus MMIO strobe bus of the MMIO master.
// The master modport is the block's view; slave is the environment's.
interface mmio_master_if;
    import mmio_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_data;
    logic              resp_err;

    logic [ADDR_W-1:0] addr_out;
    logic [DATA_W-1:0] data_out;
    logic              wr_out;
    logic              rd_out;
    logic              rd_valid_in;
    logic [DATA_W-1:0] rd_data_in;

    modport master (
        input  req_valid,
        output req_ready,
        input  req_write,
        input  req_addr,
        input  req_wdata,
        output resp_valid,
        input  resp_ready,
        output resp_data,
        output resp_err,
        output addr_out,
        output data_out,
        output wr_out,
        output rd_out,
        input  rd_valid_in,
        input  rd_data_in
    );

    modport slave (
        output req_valid,
        input  req_ready,
        output req_write,
        output req_addr,
        output req_wdata,
        input  resp_valid,
        output resp_ready,
        input  resp_data,
        input  resp_err,
        input  addr_out,
        input  data_out,
        input  wr_out,
        input  rd_out,
        output rd_valid_in,
        output rd_data_in
    );

endinterface

// File: rtl/mmio_master.sv
// Single-outstanding MMIO master: accepts one request, issues one strobe,
// waits (bounded) for read data and returns one response.
module mmio_master
    import mmio_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic          clk,
    input  logic          rst,
    mmio_master_if.master bus
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_write;
    logic              w_write_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] w_wdata_nxt;
    logic [DATA_W-1:0] r_rdata;
    logic [DATA_W-1:0] w_rdata_nxt;
    logic              r_err;
    logic              w_err_nxt;
    logic [CW-1:0]     r_cnt;
    logic [CW-1:0]     w_cnt_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_write <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_write <= w_write_nxt;
            r_addr  <= w_addr_nxt;
            r_wdata <= w_wdata_nxt;
            r_rdata <= w_rdata_nxt;
            r_err   <= w_err_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_write_nxt = r_write;
        w_addr_nxt  = r_addr;
        w_wdata_nxt = r_wdata;
        w_rdata_nxt = r_rdata;
        w_err_nxt   = r_err;
        w_cnt_nxt   = r_cnt;

        unique case (r_state)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    w_write_nxt = bus.req_write;
                    w_addr_nxt  = bus.req_addr;
                    w_wdata_nxt = bus.req_wdata;
                    w_rdata_nxt = '0;
                    // Out-of-window requests skip the bus entirely
                    if (in_window(bus.req_addr)) begin
                        w_err_nxt   = 1'b0;
                        w_state_nxt = ST_ISSUE;
                    end else begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = ST_RESP;
                    end
                end
            end
            ST_ISSUE: begin
                w_cnt_nxt = '0;
                if (r_write) begin
                    w_rdata_nxt = '0;
                    w_err_nxt   = 1'b0;
                    w_state_nxt = ST_RESP;
                end else begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Data arriving on the last allowed cycle still wins
                if (bus.rd_valid_in) begin
                    w_rdata_nxt = bus.rd_data_in;
                    w_err_nxt   = 1'b0;
                    w_state_nxt = ST_RESP;
                end else if (r_cnt == CNT_LAST) begin
                    w_rdata_nxt = '0;
                    w_err_nxt   = 1'b1;
                    w_state_nxt = ST_RESP;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_RESP: begin
                if (bus.resp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus.req_ready  = (r_state == ST_IDLE);
    assign bus.resp_valid = (r_state == ST_RESP);
    assign bus.resp_data  = r_rdata;
    assign bus.resp_err   = r_err;
    assign bus.addr_out   = r_addr;
    assign bus.data_out   = r_wdata;
    assign bus.wr_out     = (r_state == ST_ISSUE) &&  r_write;
    assign bus.rd_out     = (r_state == ST_ISSUE) && !r_write;

endmodule
